// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared encodings and byte-lane helpers for the MEM stage.
// Access sizes, lane enables, store alignment, lane merge and load extract.
package pipe_mem_pkg;

    // Access size encoding carried on MEM_size; the reserved code behaves as word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    localparam int WORD_W = 32;

    // Byte lanes touched by an access of the given size at address offset a.
    function automatic logic [3:0] lane_enable(input mem_size_e size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes so any lane can pick it up.
    function automatic logic [31:0] store_align(input mem_size_e size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Replace only the enabled byte lanes of old_w with the matching lanes of new_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    // True when the offset is not a multiple of the access size.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = |a;
        endcase
        return m;
    endfunction

    // Right-align the addressed byte/half and extend; word loads pass through.
    function automatic logic [31:0] load_extract(input mem_size_e   size,
                                                 input logic [1:0]  a,
                                                 input logic        uns,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        logic [15:0] h;
        sh = word >> {a, 3'b000};
        h  = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_mem_io_if.sv
// pipe_stage_mem_io_if: EX/MEM request bus into the MEM stage and its results.
// master = pipeline side driving the request, slave = the MEM stage.
interface pipe_stage_mem_io_if;
    logic        MEM_wmem;
    logic        MEM_rmem;
    logic [1:0]  MEM_size;
    logic        MEM_unsigned;
    logic [31:0] MEM_alu;
    logic [31:0] MEM_datain;
    logic [31:0] MEM_mem_out;
    logic        MEM_misaligned;

    modport master (
        output MEM_wmem, MEM_rmem, MEM_size, MEM_unsigned, MEM_alu, MEM_datain,
        input  MEM_mem_out, MEM_misaligned
    );

    modport slave (
        input  MEM_wmem, MEM_rmem, MEM_size, MEM_unsigned, MEM_alu, MEM_datain,
        output MEM_mem_out, MEM_misaligned
    );
endinterface

// File: rtl/pipe_mem_io_regs.sv
// pipe_mem_io_regs: memory-mapped I/O block of the MEM stage.
// Output registers with byte-lane writes, input ports, sticky change flags
// and the I/O read mux. With PIPE_STAGE_MEM_IO_SYNC_EN defined, inputs pass
// through 2-flop synchronisers plus a history stage for change detection;
// otherwise inputs are read combinationally and the change flags are 0.
module pipe_mem_io_regs
    import pipe_mem_pkg::*;
#(
    parameter int N_OUT = 3,
    parameter int N_IN  = 2,
    parameter int IOW   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [IOW-1:0]        idx_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    input  logic [32*N_IN-1:0]    in_ports_i,
    output logic [31:0]           rdata_o,
    output logic [32*N_OUT-1:0]   out_ports_o,
    output logic [N_IN-1:0]       in_changed_o
);

    logic [31:0]     idx_ext_s;
    logic [31:0]     out_q [N_OUT];
    logic [31:0]     out_d [N_OUT];
    logic [31:0]     in_vis_s [N_IN];
    logic [N_IN-1:0] chg_s;

    assign idx_ext_s = 32'(idx_i);

    // Next state of output registers: merge enabled lanes on an in-range store.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_d[k] = (wr_en_i && (idx_ext_s == 32'(k)))
                       ? merge_lanes(out_q[k], wdata_i, be_i)
                       : out_q[k];
        end
    end

    // Output register bank; reset dominates any store in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= 32'h0000_0000;
            end
        end else begin
            out_q <= out_d;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out_pack
        assign out_ports_o[32*g +: 32] = out_q[g];
    end

`ifdef PIPE_STAGE_MEM_IO_SYNC_EN
    logic [31:0]     sync1_q [N_IN];
    logic [31:0]     sync2_q [N_IN];
    logic [31:0]     hist_q  [N_IN];
    logic [N_IN-1:0] chg_q;
    logic [N_IN-1:0] chg_d;

    // Change flags: a fresh difference sets, a data-index load clears, set wins.
    always_comb begin
        chg_d = chg_q;
        for (int k = 0; k < N_IN; k++) begin
            if (sync2_q[k] != hist_q[k]) begin
                chg_d[k] = 1'b1;
            end else if (rd_en_i && (idx_ext_s == 32'(k))) begin
                chg_d[k] = 1'b0;
            end else begin
                chg_d[k] = chg_q[k];
            end
        end
    end

    // Synchroniser chain, history stage and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= 32'h0000_0000;
                sync2_q[k] <= 32'h0000_0000;
                hist_q[k]  <= 32'h0000_0000;
            end
            chg_q <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= in_ports_i[32*k +: 32];
            end
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            chg_q   <= chg_d;
        end
    end

    assign in_vis_s = sync2_q;
    assign chg_s    = chg_q;
`else
    logic unused_rd_en_s;
    assign unused_rd_en_s = rd_en_i;

    // Unsynchronised build: ports are visible directly.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            in_vis_s[k] = in_ports_i[32*k +: 32];
        end
    end

    assign chg_s = '0;
`endif

    assign in_changed_o = chg_s;

    // I/O read mux: input ports, then status word, then output read-back, else 0.
    always_comb begin
        rdata_o = 32'h0000_0000;
        for (int k = 0; k < N_IN; k++) begin
            rdata_o = rdata_o | ({32{idx_ext_s == 32'(k)}} & in_vis_s[k]);
        end
        rdata_o = rdata_o | ({32{idx_ext_s == 32'(N_IN)}} & 32'(chg_s));
        for (int k = 0; k < N_OUT; k++) begin
            rdata_o = rdata_o | ({32{idx_ext_s == 32'(N_IN + 1 + k)}} & out_q[k]);
        end
    end

endmodule

// File: rtl/pipe_stage_mem_io.sv
// pipe_stage_mem_io: MEM pipeline stage with byte/half/word data RAM and
// memory-mapped I/O. Holds the RAM array, address decode and alignment check;
// I/O registers live in pipe_mem_io_regs. Optional input synchronisers are
// enabled with the PIPE_STAGE_MEM_IO_SYNC_EN macro.
module pipe_stage_mem_io
    import pipe_mem_pkg::*;
#(
    parameter int DMEM_AW    = 5,
    parameter int N_OUT      = 3,
    parameter int N_IN       = 2,
    parameter int IO_SEL_BIT = 7
) (
    input  logic                  mem_clock,
    input  logic                  reset,
    pipe_stage_mem_io_if.slave    bus,
    input  logic [32*N_IN-1:0]    in_ports,
    output logic [32*N_OUT-1:0]   out_ports,
    output logic [N_IN-1:0]       in_changed
);

    localparam int IOW = IO_SEL_BIT - 2;

    mem_size_e          size_s;
    logic [1:0]         ofs_s;
    logic               io_sel_s;
    logic               mis_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_s;
    logic [DMEM_AW-1:0] ram_idx_s;
    logic [IOW-1:0]     io_idx_s;
    logic               ram_we_s;
    logic               io_we_s;
    logic               io_re_s;
    logic [31:0]        ram_rdata_s;
    logic [31:0]        io_rdata_s;
    logic [31:0]        mem_out_s;
    logic [31:0]        dmem_q [2**DMEM_AW];
    logic               unused_alu_s;

    // Upper address bits beyond the decode are intentionally don't-care (aliasing).
    assign unused_alu_s = ^bus.MEM_alu;

    assign size_s    = mem_size_e'(bus.MEM_size);
    assign ofs_s     = bus.MEM_alu[1:0];
    assign io_sel_s  = bus.MEM_alu[IO_SEL_BIT];
    assign ram_idx_s = bus.MEM_alu[DMEM_AW+1:2];
    assign io_idx_s  = bus.MEM_alu[IO_SEL_BIT-1:2];
    assign mis_s     = is_misaligned(size_s, ofs_s);
    assign be_s      = lane_enable(size_s, ofs_s);
    assign wdata_s   = store_align(size_s, bus.MEM_datain);

    assign ram_we_s  = bus.MEM_wmem & ~io_sel_s & ~mis_s;
    assign io_we_s   = bus.MEM_wmem &  io_sel_s & ~mis_s;
    assign io_re_s   = bus.MEM_rmem &  io_sel_s & ~mis_s;

    // Data RAM: per-lane writes, no reset of contents, writes blocked during reset.
    always_ff @(posedge mem_clock) begin
        if (!reset && ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    dmem_q[ram_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read of the pre-edge contents gives read-before-write.
    assign ram_rdata_s = dmem_q[ram_idx_s];

    pipe_mem_io_regs #(
        .N_OUT (N_OUT),
        .N_IN  (N_IN),
        .IOW   (IOW)
    ) u_io_regs (
        .clk_i        (mem_clock),
        .rst_i        (reset),
        .wr_en_i      (io_we_s),
        .rd_en_i      (io_re_s),
        .idx_i        (io_idx_s),
        .be_i         (be_s),
        .wdata_i      (wdata_s),
        .in_ports_i   (in_ports),
        .rdata_o      (io_rdata_s),
        .out_ports_o  (out_ports),
        .in_changed_o (in_changed)
    );

    // Load result: extract from RAM or I/O, zero when idle or misaligned.
    always_comb begin
        mem_out_s = 32'h0000_0000;
        if (bus.MEM_rmem && !mis_s) begin
            mem_out_s = load_extract(size_s, ofs_s, bus.MEM_unsigned,
                                     io_sel_s ? io_rdata_s : ram_rdata_s);
        end else begin
            mem_out_s = 32'h0000_0000;
        end
    end

    assign bus.MEM_mem_out    = mem_out_s;
    assign bus.MEM_misaligned = mis_s;

endmodule

// File: tb/tb_pipe_stage_mem_io.sv
// Scoreboard bench for pipe_stage_mem_io: directed loads push expected values,
// a negedge monitor pops and compares whenever a load is presented.
module tb_pipe_stage_mem_io;
    import pipe_mem_pkg::*;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_ports;
    logic [95:0] out_ports;
    logic [1:0]  in_changed;

    int vectors     = 0;
    int miscompares = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];

    pipe_stage_mem_io_if bus();

    pipe_stage_mem_io #(
        .DMEM_AW    (5),
        .N_OUT      (3),
        .N_IN       (2),
        .IO_SEL_BIT (7)
    ) dut (
        .mem_clock  (clk),
        .reset      (reset),
        .bus        (bus),
        .in_ports   (in_ports),
        .out_ports  (out_ports),
        .in_changed (in_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: loads are checked against the scoreboard; idle output must be 0.
    always @(negedge clk) begin
        if (bus.MEM_rmem === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load", 96'(bus.MEM_mem_out), 96'hx);
            end else begin
                check(name_q.pop_front(), 96'(bus.MEM_mem_out), 96'(exp_q.pop_front()));
            end
        end else begin
            check("idle_out_zero", 96'(bus.MEM_mem_out), 96'h0);
        end
    end

    task automatic op(input logic w, input logic r, input logic [1:0] sz, input logic u,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic [31:0] exp, input logic mis, input string nm);
        bus.MEM_wmem     = w;
        bus.MEM_rmem     = r;
        bus.MEM_size     = sz;
        bus.MEM_unsigned = u;
        bus.MEM_alu      = addr;
        bus.MEM_datain   = din;
        if (r) begin
            name_q.push_back(nm);
            exp_q.push_back(exp);
        end
        #1;
        check({nm, "_misaligned"}, 96'(bus.MEM_misaligned), 96'(mis));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            op(1'b0, 1'b0, W, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "idle");
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_ports = 64'h0;
        idle(2);
        check("reset_out_ports", out_ports, 96'h0);
        check("reset_in_changed", 96'(in_changed), 96'h0);
        reset = 1'b0;

        // RAM byte/half/word loads and stores
        op(1'b1, 1'b0, W, 1'b0, 32'h04, 32'h1122_3344, 32'h0, 1'b0, "sw_04");
        op(1'b0, 1'b1, B, 1'b0, 32'h07, 32'h0, 32'h0000_0011, 1'b0, "lb_07");
        op(1'b0, 1'b1, B, 1'b1, 32'h05, 32'h0, 32'h0000_0033, 1'b0, "lbu_05");
        op(1'b1, 1'b0, B, 1'b0, 32'h06, 32'h0000_00F0, 32'h0, 1'b0, "sb_06");
        op(1'b0, 1'b1, H, 1'b0, 32'h06, 32'h0, 32'h0000_11F0, 1'b0, "lh_06");
        op(1'b0, 1'b1, B, 1'b0, 32'h06, 32'h0, 32'hFFFF_FFF0, 1'b0, "lb_06");
        op(1'b0, 1'b1, B, 1'b1, 32'h06, 32'h0, 32'h0000_00F0, 1'b0, "lbu_06");
        op(1'b1, 1'b0, H, 1'b0, 32'h04, 32'h0000_8001, 32'h0, 1'b0, "sh_04");
        op(1'b0, 1'b1, H, 1'b0, 32'h04, 32'h0, 32'hFFFF_8001, 1'b0, "lh_04");
        op(1'b0, 1'b1, H, 1'b1, 32'h04, 32'h0, 32'h0000_8001, 1'b0, "lhu_04");
        op(1'b0, 1'b1, W, 1'b1, 32'h04, 32'h0, 32'h11F0_8001, 1'b0, "lw_04");

        // Misalignment
        op(1'b1, 1'b0, W, 1'b0, 32'h00, 32'h0A0B_0C0D, 32'h0, 1'b0, "sw_00");
        op(1'b1, 1'b0, W, 1'b0, 32'h02, 32'h5555_5555, 32'h0, 1'b1, "sw_02_mis");
        op(1'b0, 1'b1, W, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, "lw_02_mis");
        op(1'b0, 1'b1, W, 1'b0, 32'h00, 32'h0, 32'h0A0B_0C0D, 1'b0, "lw_00");
        op(1'b0, 1'b1, H, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, "lh_03_mis");
        op(1'b0, 1'b1, H, 1'b0, 32'h02, 32'h0, 32'h0000_0A0B, 1'b0, "lh_02");
        op(1'b1, 1'b0, H, 1'b0, 32'h01, 32'h0000_FFFF, 32'h0, 1'b1, "sh_01_mis");
        op(1'b0, 1'b1, W, 1'b0, 32'h00, 32'h0, 32'h0A0B_0C0D, 1'b0, "lw_00_again");

        // Simultaneous store and load: read returns pre-write data
        op(1'b1, 1'b0, W, 1'b0, 32'h08, 32'h0101_0101, 32'h0, 1'b0, "sw_08");
        op(1'b1, 1'b1, W, 1'b0, 32'h08, 32'h0202_0202, 32'h0101_0101, 1'b0, "rw_08");
        op(1'b0, 1'b1, W, 1'b0, 32'h08, 32'h0, 32'h0202_0202, 1'b0, "lw_08_new");

        // Output registers
        op(1'b1, 1'b0, W, 1'b0, 32'h84, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_io1");
        check("out1_word", 96'(out_ports[63:32]), 96'hDEAD_BEEF);
        op(1'b0, 1'b1, W, 1'b0, 32'h90, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_io4");
        op(1'b1, 1'b0, H, 1'b0, 32'h86, 32'h0000_1234, 32'h0, 1'b0, "sh_io1_hi");
        check("out1_half", 96'(out_ports[63:32]), 96'h1234_BEEF);
        op(1'b0, 1'b1, W, 1'b0, 32'h90, 32'h0, 32'h1234_BEEF, 1'b0, "lw_io4_b");
        op(1'b1, 1'b0, B, 1'b0, 32'h81, 32'h0000_00AA, 32'h0, 1'b0, "sb_io0_l1");
        check("out0_byte", 96'(out_ports[31:0]), 96'h0000_AA00);
        op(1'b0, 1'b1, B, 1'b1, 32'h8D, 32'h0, 32'h0000_00AA, 1'b0, "lbu_io3");
        op(1'b1, 1'b0, W, 1'b0, 32'h88, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_io2");
        op(1'b0, 1'b1, W, 1'b0, 32'h94, 32'h0, 32'hCAFE_F00D, 1'b0, "lw_io5");
        op(1'b1, 1'b0, W, 1'b0, 32'h98, 32'h5555_5555, 32'h0, 1'b0, "sw_io6_drop");
        check("out_after_drop", out_ports, {32'hCAFE_F00D, 32'h1234_BEEF, 32'h0000_AA00});
        op(1'b0, 1'b1, W, 1'b0, 32'h98, 32'h0, 32'h0, 1'b0, "lw_io6");
        op(1'b0, 1'b1, W, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b0, "lw_io31");

`ifdef PIPE_STAGE_MEM_IO_SYNC_EN
        // Synchronised inputs: visible after 2 edges, flag after 3
        in_ports[31:0] = 32'h0000_0005;
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_stat_c0");
        op(1'b0, 1'b1, W, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, "sync_in0_c1");
        op(1'b0, 1'b1, W, 1'b0, 32'h80, 32'h0, 32'h5, 1'b0, "sync_in0_c2_setwins");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h1, 1'b0, "sync_stat_c3");
        check("in_changed_p0", 96'(in_changed), 96'h1);
        op(1'b0, 1'b1, W, 1'b0, 32'h80, 32'h0, 32'h5, 1'b0, "sync_in0_clear");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_stat_cleared");
        in_ports[63:32] = 32'h0BAD_0001;
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_p1_c0");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_p1_c1");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_p1_c2");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h2, 1'b0, "sync_p1_c3");
        check("in_changed_p1", 96'(in_changed), 96'h2);
        op(1'b0, 1'b1, W, 1'b0, 32'h84, 32'h0, 32'h0BAD_0001, 1'b0, "sync_in1_clear");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "sync_p1_cleared");
`else
        // Unsynchronised inputs: combinational read, status always 0
        in_ports = {32'h0BAD_0001, 32'h0000_0005};
        op(1'b0, 1'b1, W, 1'b0, 32'h80, 32'h0, 32'h0000_0005, 1'b0, "in0_direct");
        op(1'b0, 1'b1, W, 1'b0, 32'h84, 32'h0, 32'h0BAD_0001, 1'b0, "in1_direct");
        op(1'b0, 1'b1, H, 1'b1, 32'h86, 32'h0, 32'h0000_0BAD, 1'b0, "in1_hi_half");
        op(1'b0, 1'b1, W, 1'b0, 32'h88, 32'h0, 32'h0, 1'b0, "status_zero");
        check("in_changed_tied", 96'(in_changed), 96'h0);
`endif

        // Reset mid-sequence with pending stores
        in_ports[31:0] = 32'h0000_0009;
        idle(3);
        reset = 1'b1;
        op(1'b1, 1'b0, W, 1'b0, 32'h80, 32'h0000_0077, 32'h0, 1'b0, "rst_sw_io0");
        op(1'b1, 1'b0, W, 1'b0, 32'h08, 32'h0000_0099, 32'h0, 1'b0, "rst_sw_ram");
        reset = 1'b0;
        check("midrst_out_ports", out_ports, 96'h0);
        check("midrst_in_changed", 96'(in_changed), 96'h0);
        op(1'b0, 1'b1, W, 1'b0, 32'h8C, 32'h0, 32'h0, 1'b0, "lw_io3_after_rst");
        op(1'b0, 1'b1, W, 1'b0, 32'h08, 32'h0, 32'h0202_0202, 1'b0, "lw_08_after_rst");

        idle(2);
        check("scoreboard_drained", 96'(exp_q.size()), 96'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
